// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap unit: CSR addresses,
// CSR op encodings, cause codes, mstatus field positions and FSM states.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [1:0] CSR_OP_NONE = 2'b00;
   localparam logic [1:0] CSR_OP_RW   = 2'b01;
   localparam logic [1:0] CSR_OP_RS   = 2'b10;
   localparam logic [1:0] CSR_OP_RC   = 2'b11;

   localparam logic [3:0] EXC_ILLEGAL     = 4'd2;
   localparam logic [3:0] EXC_EBREAK      = 4'd3;
   localparam logic [3:0] EXC_LOAD_FAULT  = 4'd5;
   localparam logic [3:0] EXC_STORE_FAULT = 4'd7;
   localparam logic [3:0] EXC_ECALL_M     = 4'd11;

   // irq[i] lives at mip/mie bit IRQ_CAUSE_BASE+i and reports that cause code
   localparam int IRQ_CAUSE_BASE = 16;

   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MSTATUS_MPP_LO   = 11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_REDIR = 1'b1
   } trap_state_t;

endpackage

// File: rtl/trap_csr_file.sv
// Trap CSR storage: read mux, rw/rs/rc write path, per-field masking and the
// single-edge commit of trap / mret updates.
module trap_csr_file
   import trap_pkg::*;
#(
   parameter int               XLEN        = 32,
   parameter int               NUM_IRQ     = 4,
   parameter bit               VECTORED_EN = 1'b1,
   parameter logic [XLEN-1:0]  RESET_MTVEC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   input  logic               csr_we,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic               take_trap,
   input  logic               take_mret,
   input  logic [XLEN-1:0]    trap_cause,
   input  logic [XLEN-1:0]    trap_epc,
   input  logic [XLEN-1:0]    trap_tval,
   output logic [XLEN-1:0]    csr_rdata,
   output logic               status_mie,
   output logic [NUM_IRQ-1:0] irq_enabled,
   output logic [XLEN-1:0]    mtvec,
   output logic [XLEN-1:0]    mepc
);

   // Direct-only builds also clear MODE so it always reads back 0
   localparam logic [XLEN-1:0] MTVEC_MASK = VECTORED_EN ? ~XLEN'(2) : ~XLEN'(3);

   logic               mst_mie;
   logic               mst_mpie;
   logic [NUM_IRQ-1:0] mie_q;
   logic [NUM_IRQ-1:0] mip_q;
   logic [XLEN-1:0]    mtvec_q;
   logic [XLEN-1:0]    mepc_q;
   logic [XLEN-1:0]    mcause_q;
   logic [XLEN-1:0]    mtval_q;

   logic [XLEN-1:0]    mstatus_word;
   logic [XLEN-1:0]    mie_word;
   logic [XLEN-1:0]    mip_word;
   logic [XLEN-1:0]    wnew;
   logic               write_en;

   always_comb begin
      mstatus_word = '0;
      mstatus_word[MSTATUS_MIE_BIT]       = mst_mie;
      mstatus_word[MSTATUS_MPIE_BIT]      = mst_mpie;
      mstatus_word[MSTATUS_MPP_LO +: 2]   = 2'b11;
      mie_word = '0;
      mie_word[IRQ_CAUSE_BASE +: NUM_IRQ] = mie_q;
      mip_word = '0;
      mip_word[IRQ_CAUSE_BASE +: NUM_IRQ] = mip_q;
   end

   always_comb begin
      case (csr_addr)
         CSR_MSTATUS: csr_rdata = mstatus_word;
         CSR_MIE:     csr_rdata = mie_word;
         CSR_MTVEC:   csr_rdata = mtvec_q;
         CSR_MEPC:    csr_rdata = mepc_q;
         CSR_MCAUSE:  csr_rdata = mcause_q;
         CSR_MTVAL:   csr_rdata = mtval_q;
         CSR_MIP:     csr_rdata = mip_word;
         default:     csr_rdata = '0;
      endcase
   end

   always_comb begin
      case (csr_op)
         CSR_OP_RW: wnew = csr_wdata;
         CSR_OP_RS: wnew = csr_rdata | csr_wdata;
         CSR_OP_RC: wnew = csr_rdata & ~csr_wdata;
         default:   wnew = csr_rdata;
      endcase
   end

   assign write_en = csr_we && (csr_op != CSR_OP_NONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mst_mie  <= 1'b0;
         mst_mpie <= 1'b0;
         mie_q    <= '0;
         mip_q    <= '0;
         mtvec_q  <= RESET_MTVEC & MTVEC_MASK;
         mepc_q   <= '0;
         mcause_q <= '0;
         mtval_q  <= '0;
      end else begin
         mip_q <= irq;
         if (take_trap) begin
            mepc_q   <= trap_epc & ~XLEN'(3);
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
         end else if (take_mret) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
         end else if (write_en) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  mst_mie  <= wnew[MSTATUS_MIE_BIT];
                  mst_mpie <= wnew[MSTATUS_MPIE_BIT];
               end
               CSR_MIE:    mie_q    <= wnew[IRQ_CAUSE_BASE +: NUM_IRQ];
               CSR_MTVEC:  mtvec_q  <= wnew & MTVEC_MASK;
               CSR_MEPC:   mepc_q   <= wnew & ~XLEN'(3);
               CSR_MCAUSE: mcause_q <= wnew;
               CSR_MTVAL:  mtval_q  <= wnew;
               default:    ;
            endcase
         end
      end
   end

   assign status_mie  = mst_mie;
   assign irq_enabled = mip_q & mie_q;
   assign mtvec       = mtvec_q;
   assign mepc        = mepc_q;

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap unit: picks exception / mret / interrupt at WB, commits the
// trap CSRs in one edge and drives a one-cycle registered redirect plus flushes.
module trap_controller
   import trap_pkg::*;
#(
   parameter int               XLEN        = 32,
   parameter int               NUM_IRQ     = 4,
   parameter bit               VECTORED_EN = 1'b1,
   parameter logic [XLEN-1:0]  RESET_MTVEC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [XLEN-1:0]    csr_wdata,
   output logic [XLEN-1:0]    csr_rdata,
   input  logic               exc_valid,
   input  logic [3:0]         exc_code,
   input  logic [XLEN-1:0]    exc_tval,
   input  logic               mret,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [XLEN-1:0]    epc_cur,
   input  logic [XLEN-1:0]    epc_next,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               flush_fd,
   output logic               flush_de,
   output logic               flush_em,
   output logic               flush_mw,
   output logic               regwrite_cancel,
   output logic               trap_busy
);

   // Handshake: redirect_valid is a one-cycle strobe; IF must take redirect_pc
   // in that cycle (no ready/backpressure), and the flushes are valid alongside it.

   trap_state_t        state;
   logic               status_mie;
   logic [NUM_IRQ-1:0] irq_enabled;
   logic [XLEN-1:0]    mtvec;
   logic [XLEN-1:0]    mepc;

   logic               irq_hit;
   logic [XLEN-1:0]    irq_code;
   logic               idle;
   logic               take_exc;
   logic               take_mret;
   logic               take_int;
   logic               take_trap;
   logic [XLEN-1:0]    trap_cause;
   logic [XLEN-1:0]    trap_epc;
   logic [XLEN-1:0]    trap_tval;
   logic [XLEN-1:0]    trap_base;
   logic [XLEN-1:0]    trap_target;
   logic [XLEN-1:0]    next_pc;

   // Descending scan so the lowest enabled irq index is the final winner
   always_comb begin
      irq_hit  = 1'b0;
      irq_code = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_enabled[i]) begin
            irq_hit  = 1'b1;
            irq_code = XLEN'(IRQ_CAUSE_BASE + i);
         end
      end
   end

   assign idle      = (state == ST_IDLE);
   assign take_exc  = idle && exc_valid;
   assign take_mret = idle && !exc_valid && mret;
   assign take_int  = idle && !exc_valid && !mret && status_mie && irq_hit;
   assign take_trap = take_exc || take_int;

   assign trap_cause = take_exc ? XLEN'(exc_code) : ({1'b1, {(XLEN-1){1'b0}}} | irq_code);
   assign trap_epc   = take_exc ? epc_cur  : epc_next;
   assign trap_tval  = take_exc ? exc_tval : '0;

   assign trap_base   = mtvec & ~XLEN'(3);
   assign trap_target = (VECTORED_EN && mtvec[0] && take_int) ? trap_base + (irq_code << 2)
                                                             : trap_base;
   assign next_pc     = take_mret ? mepc : trap_target;

   trap_csr_file #(
      .XLEN        (XLEN),
      .NUM_IRQ     (NUM_IRQ),
      .VECTORED_EN (VECTORED_EN),
      .RESET_MTVEC (RESET_MTVEC)
   ) u_csr (
      .clk         (clk),
      .rst         (rst),
      .csr_op      (csr_op),
      .csr_addr    (csr_addr),
      .csr_wdata   (csr_wdata),
      .csr_we      (idle && !take_trap && !take_mret),
      .irq         (irq),
      .take_trap   (take_trap),
      .take_mret   (take_mret),
      .trap_cause  (trap_cause),
      .trap_epc    (trap_epc),
      .trap_tval   (trap_tval),
      .csr_rdata   (csr_rdata),
      .status_mie  (status_mie),
      .irq_enabled (irq_enabled),
      .mtvec       (mtvec),
      .mepc        (mepc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         redirect_valid  <= 1'b0;
         redirect_pc     <= '0;
         flush_fd        <= 1'b0;
         flush_de        <= 1'b0;
         flush_em        <= 1'b0;
         flush_mw        <= 1'b0;
         regwrite_cancel <= 1'b0;
      end else begin
         redirect_valid  <= 1'b0;
         flush_fd        <= 1'b0;
         flush_de        <= 1'b0;
         flush_em        <= 1'b0;
         flush_mw        <= 1'b0;
         regwrite_cancel <= 1'b0;
         if (state == ST_IDLE) begin
            if (take_trap || take_mret) begin
               state          <= ST_REDIR;
               redirect_valid <= 1'b1;
               redirect_pc    <= next_pc;
               flush_fd       <= 1'b1;
               flush_de       <= 1'b1;
               flush_em       <= 1'b1;
               // Only an exception kills the WB instruction; interrupts let it retire
               flush_mw        <= take_exc;
               regwrite_cancel <= take_exc;
            end
         end else begin
            state <= ST_IDLE;
         end
      end
   end

   assign trap_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: directed scenarios plus random traffic
// checked against a CSR-level reference model.
module tb_trap_controller;

   localparam int          XLEN      = 32;
   localparam int          NUM_IRQ   = 4;
   localparam logic [31:0] RST_MTVEC = 32'h0000_1000;

   logic               clk = 1'b0;
   logic               rst;
   logic [1:0]         csr_op;
   logic [11:0]        csr_addr;
   logic [31:0]        csr_wdata;
   logic [31:0]        csr_rdata;
   logic               exc_valid;
   logic [3:0]         exc_code;
   logic [31:0]        exc_tval;
   logic               mret;
   logic [NUM_IRQ-1:0] irq;
   logic [31:0]        epc_cur;
   logic [31:0]        epc_next;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic               flush_fd, flush_de, flush_em, flush_mw;
   logic               regwrite_cancel;
   logic               trap_busy;
   logic               rd_chk = 1'b0;

   always #5 clk = ~clk;

   trap_controller #(
      .XLEN        (XLEN),
      .NUM_IRQ     (NUM_IRQ),
      .VECTORED_EN (1'b1),
      .RESET_MTVEC (RST_MTVEC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .csr_op          (csr_op),
      .csr_addr        (csr_addr),
      .csr_wdata       (csr_wdata),
      .csr_rdata       (csr_rdata),
      .exc_valid       (exc_valid),
      .exc_code        (exc_code),
      .exc_tval        (exc_tval),
      .mret            (mret),
      .irq             (irq),
      .epc_cur         (epc_cur),
      .epc_next        (epc_next),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .flush_fd        (flush_fd),
      .flush_de        (flush_de),
      .flush_em        (flush_em),
      .flush_mw        (flush_mw),
      .regwrite_cancel (regwrite_cancel),
      .trap_busy       (trap_busy)
   );

   typedef struct {
      logic [31:0] pc;
      logic        kill_wb;
      int          cyc;
   } redir_t;

   redir_t      redir_q[$];
   logic [31:0] exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_mie, m_mpie, m_busy;
   logic [31:0] m_mie_reg, m_mtvec, m_mepc, m_mcause, m_mtval, m_mip;

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_busy = 0;
      m_mie_reg = 0; m_mtvec = RST_MTVEC; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mip = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         12'h304: return m_mie_reg;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         12'h344: return m_mip;
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_trap(input bit is_int, input logic [31:0] code, input logic [31:0] epc,
                         input logic [31:0] tval);
      redir_t      r;
      logic [31:0] base;
      base = m_mtvec & ~32'h3;
      r.pc = (is_int && m_mtvec[0]) ? base + 4 * code : base;
      r.kill_wb = !is_int;
      r.cyc = cyc + 1;
      redir_q.push_back(r);
      m_mepc   = epc & ~32'h3;
      m_mcause = is_int ? (32'h8000_0000 | code) : code;
      m_mtval  = is_int ? 32'h0 : tval;
      m_mpie   = m_mie;
      m_mie    = 0;
      m_busy   = 1;
   endtask

   // Predicts the effect of the inputs about to be sampled at the next edge
   task automatic model_step();
      logic [31:0] nxt_mip, old, nv;
      int          pend;
      redir_t      r;
      nxt_mip = 32'(irq) << 16;
      if (m_busy) begin
         m_busy = 0;
      end else begin
         pend = -1;
         for (int i = 0; i < NUM_IRQ; i++)
            if (pend < 0 && m_mie && m_mip[16+i] && m_mie_reg[16+i]) pend = i;
         if (exc_valid) begin
            m_trap(0, 32'(exc_code), epc_cur, exc_tval);
         end else if (mret) begin
            r.pc = m_mepc; r.kill_wb = 0; r.cyc = cyc + 1;
            redir_q.push_back(r);
            m_mie = m_mpie; m_mpie = 1; m_busy = 1;
         end else if (pend >= 0) begin
            m_trap(1, 32'(16 + pend), epc_next, 32'h0);
         end else if (csr_op != 2'b00) begin
            old = m_read(csr_addr);
            nv = (csr_op == 2'b01) ? csr_wdata :
                 (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
            case (csr_addr)
               12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
               12'h304: m_mie_reg = nv & 32'h000F_0000;
               12'h305: m_mtvec   = nv & ~32'h2;
               12'h341: m_mepc    = nv & ~32'h3;
               12'h342: m_mcause  = nv;
               12'h343: m_mtval   = nv;
               default: ;
            endcase
         end
      end
      m_mip = nxt_mip;
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      if (rd_chk) exp_q.push_back(m_read(csr_addr));
      model_step();
      @(posedge clk); #1;
      rd_chk = 0; csr_op = 2'b00; exc_valid = 0; mret = 0;
   endtask

   task automatic csr_cmd(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
      csr_op = op; csr_addr = a; csr_wdata = d;
      tick();
   endtask

   task automatic read_chk(input logic [11:0] a);
      csr_addr = a; rd_chk = 1;
      tick();
   endtask

   task automatic raise_exc(input logic [3:0] code, input logic [31:0] epc, input logic [31:0] tval);
      exc_valid = 1; exc_code = code; epc_cur = epc; exc_tval = tval;
      tick();
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) tick();
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (rd_chk) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL csr_rdata: no expectation queued for addr %h", csr_addr);
            end else begin
               check("csr_rdata", csr_rdata, exp_q.pop_front());
            end
         end
         if (redirect_valid) begin
            if (redir_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL spurious_redirect: got pc %h expected no redirect", redirect_pc);
            end else begin
               redir_t e;
               e = redir_q.pop_front();
               check("redirect_pc", redirect_pc, e.pc);
               check("redirect_cycle", 32'(cyc), 32'(e.cyc));
               check("flush_fd_de_em", {29'b0, flush_fd, flush_de, flush_em}, 32'h7);
               check("flush_mw", {31'b0, flush_mw}, {31'b0, e.kill_wb});
               check("regwrite_cancel", {31'b0, regwrite_cancel}, {31'b0, e.kill_wb});
               check("trap_busy", {31'b0, trap_busy}, 32'h1);
            end
         end else begin
            check("idle_outputs", {26'b0, flush_fd, flush_de, flush_em, flush_mw,
                                   regwrite_cancel, trap_busy}, 32'h0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   logic [11:0] addr_tab [8];
   logic [3:0]  code_tab [5];

   initial begin
      addr_tab = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h301};
      code_tab = '{4'd2, 4'd3, 4'd5, 4'd7, 4'd11};
      rst = 1; csr_op = 0; csr_addr = 0; csr_wdata = 0; exc_valid = 0; exc_code = 0;
      exc_tval = 0; mret = 0; irq = 0; epc_cur = 0; epc_next = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {25'b0, redirect_valid, flush_fd, flush_de, flush_em, flush_mw,
                              regwrite_cancel, trap_busy}, 32'h0);
      check("reset_redirect_pc", redirect_pc, 32'h0);
      rst = 0;
      model_reset();
      for (int i = 0; i < 8; i++) read_chk(addr_tab[i]);

      // Direct-mode exception with MIE=1 beforehand
      csr_cmd(2'b01, 12'h305, 32'h100);
      csr_cmd(2'b10, 12'h300, 32'h8);
      raise_exc(4'd2, 32'h40, 32'hDEAD_BEEF);
      idle_cycles(1);
      read_chk(12'h341); read_chk(12'h342); read_chk(12'h343); read_chk(12'h300);

      // Vectored interrupt: irq 1 and 2 pending, only bit 17 enabled
      csr_cmd(2'b01, 12'h305, 32'h201);
      csr_cmd(2'b10, 12'h304, 32'h0002_0000);
      irq = 4'b0110; epc_next = 32'h80;
      csr_cmd(2'b10, 12'h300, 32'h8);
      idle_cycles(3);
      irq = 4'b0000;
      read_chk(12'h341); read_chk(12'h342); read_chk(12'h343); read_chk(12'h300);

      // mret back to mepc
      mret = 1; tick();
      idle_cycles(1);
      read_chk(12'h300);

      // Exception beats mret and irq; the same-cycle CSR write is dropped
      exc_valid = 1; exc_code = 4'd7; epc_cur = 32'h44; exc_tval = 32'h1234;
      mret = 1; irq = 4'b0001;
      csr_op = 2'b01; csr_addr = 12'h305; csr_wdata = 32'h5555_0000;
      tick();
      irq = 4'b0000;
      idle_cycles(1);
      read_chk(12'h305); read_chk(12'h342);

      // Field masking
      csr_cmd(2'b10, 12'h304, 32'hFFFF_FFFF); read_chk(12'h304);
      csr_cmd(2'b11, 12'h304, 32'hFFFF_FFFF); read_chk(12'h304);
      irq = 4'b1010;
      csr_cmd(2'b01, 12'h344, 32'h0); read_chk(12'h344);
      csr_cmd(2'b01, 12'h341, 32'h103); read_chk(12'h341);
      csr_cmd(2'b01, 12'h305, 32'h0000_0403); read_chk(12'h305);
      irq = 4'b0000;

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 9) == 0) irq = NUM_IRQ'($urandom_range(0, 15));
         epc_cur  = $urandom;
         epc_next = $urandom;
         rd_chk   = 1'($urandom_range(0, 1));
         csr_addr = addr_tab[$urandom_range(0, 7)];
         if (r < 6) begin
            exc_valid = 1; exc_code = code_tab[$urandom_range(0, 4)]; exc_tval = $urandom;
         end else if (r < 10) begin
            mret = 1;
         end else if (r < 50) begin
            csr_op = 2'($urandom_range(1, 3));
            csr_wdata = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4095));
         end
         tick();
      end

      // Reset while a redirect is in flight
      irq = 4'b0000;
      idle_cycles(4);
      raise_exc(4'd3, 32'h10, 32'h0);
      check("redirect_before_rst", {31'b0, redirect_valid}, 32'h1);
      #2 rst = 1;
      #1;
      check("rst_drops_redirect", {31'b0, redirect_valid}, 32'h0);
      check("rst_drops_busy", {31'b0, trap_busy}, 32'h0);
      check("rst_drops_flush", {28'b0, flush_fd, flush_de, flush_em, flush_mw}, 32'h0);
      redir_q.delete();
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      read_chk(12'h305); read_chk(12'h300); read_chk(12'h342);
      idle_cycles(2);

      check("redirects_outstanding", 32'(redir_q.size()), 32'h0);
      check("reads_outstanding", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
